// File: rtl/ex_muldiv.sv
// ex_muldiv: multi-cycle RV32M multiply/divide unit beside the execute ALU.
// Iterative shift-add multiplier and restoring divider on operand magnitudes,
// with sign correction applied in a single FIX cycle.
// Optional macro MULDIV_FAST_MUL_EN: multiplies bypass CALC and use a
// single-cycle XLEN x XLEN product in FIX; division is unaffected.
module ex_muldiv #(
    parameter int unsigned XLEN               = 32,
    parameter int unsigned MUL_BITS_PER_CYCLE = 4,
    parameter int unsigned DIV_BITS_PER_CYCLE = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            start_i,
    input  logic            flush_i,
    input  logic [2:0]      op_i,
    input  logic [XLEN-1:0] op1_i,
    input  logic [XLEN-1:0] op2_i,
    input  logic [4:0]      rd_addr_i,
    output logic            busy_o,
    output logic            hold_flag_o,
    output logic            valid_o,
    output logic [XLEN-1:0] result_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_wen_o
);

    localparam int unsigned MB = MUL_BITS_PER_CYCLE;
    localparam int unsigned DB = DIV_BITS_PER_CYCLE;
    localparam int unsigned CW = $clog2(XLEN + 1);
    localparam logic [CW-1:0] MUL_N = CW'(XLEN / MB);
    localparam logic [CW-1:0] DIV_N = CW'(XLEN / DB);
    localparam logic [XLEN-1:0] INT_MIN = {1'b1, {(XLEN-1){1'b0}}};

    typedef enum logic [1:0] {
        S_IDLE,
        S_CALC,
        S_FIX,
        S_DONE
    } state_e;

    typedef enum logic [2:0] {
        OP_MUL    = 3'd0,
        OP_MULH   = 3'd1,
        OP_MULHSU = 3'd2,
        OP_MULHU  = 3'd3,
        OP_DIV    = 3'd4,
        OP_DIVU   = 3'd5,
        OP_REM    = 3'd6,
        OP_REMU   = 3'd7
    } op_e;

    state_e state, state_nxt;
    op_e    op_in, op_q;

    logic [CW-1:0]     count;
    logic [XLEN-1:0]   a_q;       // multiplicand (mul) or divisor (div) magnitude
    logic [2*XLEN-1:0] acc;       // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic              neg_q;     // negate product / quotient
    logic              rem_neg_q; // remainder takes dividend sign

    // Operand decode for the request presented in IDLE
    logic            accept, in_s1, in_s2, div_zero, div_ovf, special;
    logic [XLEN-1:0] mag1, mag2, special_res;

    // Iteration step results
    logic [XLEN+MB-1:0] mul_part, mul_sum;
    logic [2*XLEN-1:0]  mul_next, div_next, prod_mag, prod;
    logic [XLEN-1:0]    rem_w, quo_w, quot_fix, rem_fix, fix_res;
    logic [XLEN:0]      trial;

    assign op_in  = op_e'(op_i);
    assign accept = (state == S_IDLE) & start_i & ~flush_i;

    assign in_s1 = op1_i[XLEN-1] & (op_in inside {OP_MULH, OP_MULHSU, OP_DIV, OP_REM});
    assign in_s2 = op2_i[XLEN-1] & (op_in inside {OP_MULH, OP_DIV, OP_REM});
    assign mag1  = in_s1 ? -op1_i : op1_i;
    assign mag2  = in_s2 ? -op2_i : op2_i;

    assign div_zero = op_i[2] & (op2_i == '0);
    assign div_ovf  = (op_in inside {OP_DIV, OP_REM}) & (op1_i == INT_MIN) & (op2_i == '1);
    assign special  = div_zero | div_ovf;
    assign special_res = div_zero ? (op_i[1] ? op1_i : '1)
                                  : (op_i[1] ? '0 : op1_i);

    assign busy_o      = (state != S_IDLE);
    assign hold_flag_o = accept | (state == S_CALC) | (state == S_FIX);
    assign valid_o     = (state == S_DONE);
    assign rd_wen_o    = valid_o & (rd_addr_o != '0);

`ifdef MULDIV_FAST_MUL_EN
    // Multiplies never iterate; the step value is a pass-through
    always_comb begin
        mul_part = '0;
        mul_sum  = '0;
        mul_next = acc;
    end
`else
    // One radix-2^MB shift-add step: add digit*multiplicand into the upper half, shift right
    always_comb begin
        mul_part = '0;
        for (int unsigned i = 0; i < MB; i++) begin
            if (acc[i]) begin
                mul_part = mul_part + ((XLEN+MB)'(a_q) << i);
            end
        end
        mul_sum  = (XLEN+MB)'(acc[2*XLEN-1:XLEN]) + mul_part;
        mul_next = {mul_sum, acc[XLEN-1:MB]};
    end
`endif

    // DB restoring subtract-shift steps, one quotient bit each
    always_comb begin
        rem_w = acc[2*XLEN-1:XLEN];
        quo_w = acc[XLEN-1:0];
        trial = '0;
        for (int unsigned i = 0; i < DB; i++) begin
            trial = {rem_w, quo_w[XLEN-1]};
            quo_w = {quo_w[XLEN-2:0], 1'b0};
            if (trial >= {1'b0, a_q}) begin
                trial    = trial - {1'b0, a_q};
                quo_w[0] = 1'b1;
            end
            rem_w = trial[XLEN-1:0];
        end
        div_next = {rem_w, quo_w};
    end

    // Sign correction and result selection used in FIX
    always_comb begin
`ifdef MULDIV_FAST_MUL_EN
        prod_mag = (2*XLEN)'(a_q) * (2*XLEN)'(acc[XLEN-1:0]);
`else
        prod_mag = acc;
`endif
        prod     = neg_q ? -prod_mag : prod_mag;
        quot_fix = neg_q ? -acc[XLEN-1:0] : acc[XLEN-1:0];
        rem_fix  = rem_neg_q ? -acc[2*XLEN-1:XLEN] : acc[2*XLEN-1:XLEN];
        fix_res  = '0;
        case (op_q)
            OP_MUL:                        fix_res = prod[XLEN-1:0];
            OP_MULH, OP_MULHSU, OP_MULHU:  fix_res = prod[2*XLEN-1:XLEN];
            OP_DIV, OP_DIVU:               fix_res = quot_fix;
            default:                       fix_res = rem_fix;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_nxt;
    end

    // Next-state logic; flush overrides every state
    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (start_i) begin
                    if (special)       state_nxt = S_DONE;
`ifdef MULDIV_FAST_MUL_EN
                    else if (!op_i[2]) state_nxt = S_FIX;
`endif
                    else               state_nxt = S_CALC;
                end
            end
            S_CALC:  if (count == CW'(1)) state_nxt = S_FIX;
            S_FIX:   state_nxt = S_DONE;
            default: state_nxt = S_IDLE;
        endcase
        if (flush_i) state_nxt = S_IDLE;
    end

    // Operand capture, iteration and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= OP_MUL;
            count     <= '0;
            a_q       <= '0;
            acc       <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            result_o  <= '0;
            rd_addr_o <= '0;
        end else if (flush_i) begin
            count     <= '0;
            result_o  <= '0;
            rd_addr_o <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start_i) begin
                        op_q      <= op_in;
                        rd_addr_o <= rd_addr_i;
                        neg_q     <= in_s1 ^ in_s2;
                        rem_neg_q <= in_s1;
                        count     <= op_i[2] ? DIV_N : MUL_N;
                        a_q       <= op_i[2] ? mag2 : mag1;
                        acc       <= {{XLEN{1'b0}}, (op_i[2] ? mag1 : mag2)};
                        if (special) result_o <= special_res;
                    end
                end
                S_CALC: begin
                    acc   <= op_q[2] ? div_next : mul_next;
                    count <= count - CW'(1);
                end
                S_FIX:   result_o <= fix_res;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_ex_muldiv.sv
// tb_ex_muldiv: randomized and directed checks of ex_muldiv against a
// 64-bit arithmetic reference model of the RV32M operations.
module tb_ex_muldiv;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start_i = 1'b0;
    logic        flush_i = 1'b0;
    logic [2:0]  op_i = '0;
    logic [31:0] op1_i = '0;
    logic [31:0] op2_i = '0;
    logic [4:0]  rd_addr_i = '0;
    logic        busy_o, hold_flag_o, valid_o, rd_wen_o;
    logic [31:0] result_o;
    logic [4:0]  rd_addr_o;

    int n_checks = 0;
    int n_pass   = 0;

    always #5 clk = ~clk;

    ex_muldiv #(.XLEN(32), .MUL_BITS_PER_CYCLE(4), .DIV_BITS_PER_CYCLE(1)) dut (
        .clk(clk), .rst(rst), .start_i(start_i), .flush_i(flush_i),
        .op_i(op_i), .op1_i(op1_i), .op2_i(op2_i), .rd_addr_i(rd_addr_i),
        .busy_o(busy_o), .hold_flag_o(hold_flag_o), .valid_o(valid_o),
        .result_o(result_o), .rd_addr_o(rd_addr_o), .rd_wen_o(rd_wen_o)
    );

    function automatic logic [31:0] ref_result(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        longint      sa, sb, ub, p;
        logic [63:0] up;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        ub = longint'({32'b0, b});
        up = {32'b0, a} * {32'b0, b};
        p  = 0;
        case (op)
            3'd0: return up[31:0];
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: return up[63:32];
            3'd4: begin if (b == 0) return 32'hFFFFFFFF; p = sa / sb; return p[31:0]; end
            3'd5: begin if (b == 0) return 32'hFFFFFFFF; return a / b; end
            3'd6: begin if (b == 0) return a; p = sa % sb; return p[31:0]; end
            default: begin if (b == 0) return a; return a % b; end
        endcase
    endfunction

    function automatic int ref_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
        if (op[2] && b == 0) return 1;
        if (op[2] && !op[0] && a == 32'h80000000 && b == 32'hFFFFFFFF) return 1;
`ifdef MULDIV_FAST_MUL_EN
        if (!op[2]) return 2;
`else
        if (!op[2]) return 10;
`endif
        return 34;
    endfunction

    // Issue one op and wait (bounded) for valid_o; lat=0 means it never came.
    task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [4:0] rd, output logic [31:0] res, output int lat,
                          output logic [4:0] rdo, output logic wen, output logic hold_ok);
        hold_ok = 1'b1; lat = 0; res = '0; rdo = '0; wen = 1'b0;
        @(negedge clk);
        op_i = op; op1_i = a; op2_i = b; rd_addr_i = rd; start_i = 1'b1;
        #1 if (hold_flag_o !== 1'b1) hold_ok = 1'b0;
        @(posedge clk);
        #1 start_i = 1'b0; op1_i = $urandom; op2_i = $urandom; rd_addr_i = 5'($urandom);
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (valid_o === 1'b1) begin
                lat = c; res = result_o; rdo = rd_addr_o; wen = rd_wen_o;
                if (hold_flag_o !== 1'b0) hold_ok = 1'b0;
                break;
            end
            if (hold_flag_o !== 1'b1) hold_ok = 1'b0;
        end
    endtask

    task automatic test_reset;
        #1;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy got %b want 0", busy_o); else n_pass++;
        n_checks++; if (hold_flag_o !== 1'b0) $display("FAIL reset_hold got %b want 0", hold_flag_o); else n_pass++;
        n_checks++; if (valid_o !== 1'b0) $display("FAIL reset_valid got %b want 0", valid_o); else n_pass++;
        n_checks++; if (result_o !== 32'h0) $display("FAIL reset_result got %h want 0", result_o); else n_pass++;
        n_checks++; if (rd_addr_o !== 5'h0) $display("FAIL reset_rd got %h want 0", rd_addr_o); else n_pass++;
        n_checks++; if (rd_wen_o !== 1'b0) $display("FAIL reset_wen got %b want 0", rd_wen_o); else n_pass++;
        @(negedge clk); rst = 1'b0;
    endtask

    task automatic test_directed;
        logic [2:0]  ops [10] = '{3'd0, 3'd3, 3'd2, 3'd4, 3'd6, 3'd5, 3'd7, 3'd4, 3'd6, 3'd1};
        logic [31:0] as  [10] = '{32'd7, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFF9, 32'hFFFFFFF9,
                                  32'd5, 32'd5, 32'h80000000, 32'h80000000, 32'h80000000};
        logic [31:0] bs  [10] = '{32'hFFFFFFFD, 32'hFFFFFFFF, 32'd2, 32'd2, 32'd2,
                                  32'd0, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h80000000};
        logic [31:0] exp [10] = '{32'hFFFFFFEB, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFD, 32'hFFFFFFFF,
                                  32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0, 32'h40000000};
        logic [31:0] res; int lat; logic [4:0] rdo; logic wen, hok;
        for (int i = 0; i < 10; i++) begin
            run_op(ops[i], as[i], bs[i], 5'd3, res, lat, rdo, wen, hok);
            n_checks++; if (res !== exp[i]) $display("FAIL directed%0d_result got %h want %h", i, res, exp[i]); else n_pass++;
            n_checks++; if (lat !== ref_lat(ops[i], as[i], bs[i])) $display("FAIL directed%0d_latency got %0d want %0d", i, lat, ref_lat(ops[i], as[i], bs[i])); else n_pass++;
            n_checks++; if (hok !== 1'b1) $display("FAIL directed%0d_hold got %b want 1", i, hok); else n_pass++;
        end
    endtask

    task automatic test_random;
        logic [2:0] op; logic [31:0] a, b, res; logic [4:0] rd, rdo; int lat; logic wen, hok;
        for (int i = 0; i < 60; i++) begin
            op = 3'($urandom);
            case ($urandom_range(0, 5))
                0: a = 32'h80000000; 1: a = 32'hFFFFFFFF; 2: a = 32'($urandom_range(0, 20));
                default: a = $urandom;
            endcase
            case ($urandom_range(0, 6))
                0: b = 32'h0; 1: b = 32'hFFFFFFFF; 2: b = 32'($urandom_range(1, 9)); 3: b = 32'h80000000;
                default: b = $urandom;
            endcase
            rd = 5'($urandom);
            run_op(op, a, b, rd, res, lat, rdo, wen, hok);
            n_checks++; if (res !== ref_result(op, a, b)) $display("FAIL rand%0d_result op=%0d a=%h b=%h got %h want %h", i, op, a, b, res, ref_result(op, a, b)); else n_pass++;
            n_checks++; if (lat !== ref_lat(op, a, b)) $display("FAIL rand%0d_latency got %0d want %0d", i, lat, ref_lat(op, a, b)); else n_pass++;
            n_checks++; if (rdo !== rd) $display("FAIL rand%0d_rd got %h want %h", i, rdo, rd); else n_pass++;
            n_checks++; if (wen !== (rd != 0)) $display("FAIL rand%0d_wen got %b want %b", i, wen, rd != 0); else n_pass++;
            n_checks++; if (hok !== 1'b1) $display("FAIL rand%0d_hold got %b want 1", i, hok); else n_pass++;
        end
    endtask

    task automatic test_rd_zero;
        logic [31:0] res; int lat; logic [4:0] rdo; logic wen, hok;
        run_op(3'd0, 32'd6, 32'd9, 5'd0, res, lat, rdo, wen, hok);
        n_checks++; if (lat !== ref_lat(3'd0, 32'd6, 32'd9)) $display("FAIL rd0_latency got %0d want %0d", lat, ref_lat(3'd0, 32'd6, 32'd9)); else n_pass++;
        n_checks++; if (wen !== 1'b0) $display("FAIL rd0_wen got %b want 0", wen); else n_pass++;
        n_checks++; if (res !== 32'd54) $display("FAIL rd0_result got %h want 36", res); else n_pass++;
    endtask

    task automatic test_start_in_done;
        logic [31:0] res; int lat; logic [4:0] rdo; logic wen, hok;
        run_op(3'd5, 32'd5, 32'd0, 5'd1, res, lat, rdo, wen, hok);
        start_i = 1'b1; op_i = 3'd0; op1_i = 32'd2; op2_i = 32'd3;
        @(posedge clk); #1 start_i = 1'b0;
        @(negedge clk);
        n_checks++; if (busy_o !== 1'b0) $display("FAIL start_in_done_busy got %b want 0", busy_o); else n_pass++;
        n_checks++; if (valid_o !== 1'b0) $display("FAIL start_in_done_valid got %b want 0", valid_o); else n_pass++;
    endtask

    task automatic test_flush;
        logic seen; logic [31:0] res; int lat; logic [4:0] rdo; logic wen, hok;
        @(negedge clk);
        op_i = 3'd4; op1_i = 32'd1000; op2_i = 32'd7; rd_addr_i = 5'd9; start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        repeat (5) @(negedge clk);
        n_checks++; if (busy_o !== 1'b1) $display("FAIL flush_busy_before got %b want 1", busy_o); else n_pass++;
        flush_i = 1'b1;
        @(posedge clk); #1 flush_i = 1'b0;
        @(negedge clk);
        n_checks++; if (busy_o !== 1'b0) $display("FAIL flush_busy_after got %b want 0", busy_o); else n_pass++;
        n_checks++; if (hold_flag_o !== 1'b0) $display("FAIL flush_hold got %b want 0", hold_flag_o); else n_pass++;
        n_checks++; if (rd_addr_o !== 5'd0) $display("FAIL flush_rd got %h want 0", rd_addr_o); else n_pass++;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin @(negedge clk); if (valid_o === 1'b1) seen = 1'b1; end
        n_checks++; if (seen !== 1'b0) $display("FAIL flush_valid got %b want 0", seen); else n_pass++;
        run_op(3'd0, 32'd7, 32'hFFFFFFFD, 5'd4, res, lat, rdo, wen, hok);
        n_checks++; if (res !== 32'hFFFFFFEB) $display("FAIL flush_then_mul got %h want ffffffeb", res); else n_pass++;
        // flush together with start in IDLE wins
        @(negedge clk);
        start_i = 1'b1; flush_i = 1'b1; op_i = 3'd4; op1_i = 32'd9; op2_i = 32'd3;
        #1 n_checks++; if (hold_flag_o !== 1'b0) $display("FAIL flush_start_hold got %b want 0", hold_flag_o); else n_pass++;
        @(posedge clk); #1 start_i = 1'b0; flush_i = 1'b0;
        @(negedge clk);
        n_checks++; if (busy_o !== 1'b0) $display("FAIL flush_start_busy got %b want 0", busy_o); else n_pass++;
    endtask

    task automatic test_reset_mid;
        logic seen;
        @(negedge clk);
        op_i = 3'd6; op1_i = 32'd12345; op2_i = 32'd17; rd_addr_i = 5'd5; start_i = 1'b1;
        @(posedge clk); #1 start_i = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        #1;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL rst_mid_busy got %b want 0", busy_o); else n_pass++;
        n_checks++; if (result_o !== 32'h0) $display("FAIL rst_mid_result got %h want 0", result_o); else n_pass++;
        n_checks++; if (rd_addr_o !== 5'h0) $display("FAIL rst_mid_rd got %h want 0", rd_addr_o); else n_pass++;
        n_checks++; if (hold_flag_o !== 1'b0) $display("FAIL rst_mid_hold got %b want 0", hold_flag_o); else n_pass++;
        @(negedge clk); rst = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 40; c++) begin @(negedge clk); if (valid_o === 1'b1 || busy_o === 1'b1) seen = 1'b1; end
        n_checks++; if (seen !== 1'b0) $display("FAIL rst_mid_activity got %b want 0", seen); else n_pass++;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got timeout want completion");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_directed;
        test_rd_zero;
        test_start_in_done;
        test_flush;
        test_reset_mid;
        test_random;
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
